// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round sequencer.
// SHA224_MODE_EN (optional) enables the SHA-224 IV and truncated digest output.
package sha256_pkg;

  localparam int unsigned WORDS_DEF  = 16;
  localparam int unsigned ROUNDS_DEF = 64;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CHAIN_W    = 256;
  localparam int unsigned RIDX_W     = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CORE_IDLE   = 2'd0,
    CORE_R0_15  = 2'd1,
    CORE_R16_63 = 2'd2,
    CORE_R64    = 2'd3
  } core_fsm_e;

  // Eight 32-bit chaining words, H0 in the top slot.
  typedef logic [7:0][WORD_W-1:0] chain_t;

  localparam chain_t SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam chain_t SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

endpackage

// File: rtl/sha256_chain_reg.sv
// 8x32 chaining-value register: IV load at block start, capture at final add, else hold.
module sha256_chain_reg
  import sha256_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_iv_i,
  input  logic [CHAIN_W-1:0] iv_i,
  input  logic               capture_i,
  input  logic [CHAIN_W-1:0] capture_data_i,
  output logic [CHAIN_W-1:0] chain_o
);

  chain_t chain_d, chain_q;

  always_comb begin
    chain_d = chain_q;
    if (load_iv_i) begin
      chain_d = iv_i;
    end else if (capture_i) begin
      chain_d = capture_data_i;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain_q <= SHA256_IV;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign chain_o = chain_q;

endmodule

// File: rtl/sha256_round_ctrl.sv
// Block sequencer for the SHA-256 compression core: word load, round loop, digest capture.
// SHA224_MODE_EN adds mode224_in (SHA-224 IV select) and digest224_out.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned ROUNDS = ROUNDS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_in,
  input  logic               first_block_in,
  input  logic               msg_valid_in,
  input  logic [31:0]        msg_data_in,
  output logic               msg_ready_out,
  output logic               sched_we_out,
  output logic [3:0]         sched_idx_out,
  output logic [31:0]        sched_data_out,
  output logic               core_start_out,
  output logic [1:0]         core_fsm_out,
  output logic [6:0]         core_round_out,
  output logic [255:0]       chain_out,
  input  logic [255:0]       core_digest_in,
  input  logic               core_valid_in,
  output logic [255:0]       digest_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               error_out
`ifdef SHA224_MODE_EN
  ,
  input  logic               mode224_in,
  output logic [223:0]       digest224_out
`endif
);

  localparam int unsigned WCNT_W = $clog2(WORDS);
  localparam int unsigned RCNT_W = $clog2(ROUNDS);

  state_e              state_q;
  core_fsm_e           core_fsm_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [RCNT_W-1:0]   rcnt_q;
  logic [RIDX_W-1:0]   round_q;
  logic [RIDX_W-1:0]   round_nx_c;
  logic                ready_q, we_q, core_start_q, busy_q, done_q, err_q;
  logic [3:0]          idx_q;
  logic [WORD_W-1:0]   data_q;
  logic                load_iv_c, capture_c;
  logic [CHAIN_W-1:0]  iv_c, chain_c;

  assign round_nx_c = RIDX_W'(rcnt_q) + RIDX_W'(1);
  assign load_iv_c  = (state_q == S_IDLE) && start_in && first_block_in;
  assign capture_c  = (state_q == S_FINAL) && core_valid_in;

`ifdef SHA224_MODE_EN
  assign iv_c = mode224_in ? SHA224_IV : SHA256_IV;
`else
  assign iv_c = SHA256_IV;
`endif

  // Sequencer: all strobes and core controls are registered alongside the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      core_fsm_q   <= CORE_IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      round_q      <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            wcnt_q  <= '0;
          end
        end
        S_LOAD: begin
          if (msg_valid_in) begin
            we_q   <= 1'b1;
            idx_q  <= 4'(wcnt_q);
            data_q <= msg_data_in;
            if (wcnt_q == WCNT_W'(WORDS - 1)) begin
              state_q      <= S_INIT;
              ready_q      <= 1'b0;
              core_start_q <= 1'b1;
              core_fsm_q   <= CORE_IDLE;
            end else begin
              wcnt_q <= wcnt_q + WCNT_W'(1);
            end
          end
        end
        S_INIT: begin
          state_q    <= S_ROUND;
          core_fsm_q <= CORE_R0_15;
          rcnt_q     <= '0;
          round_q    <= '0;
        end
        S_ROUND: begin
          if (rcnt_q == RCNT_W'(ROUNDS - 1)) begin
            state_q    <= S_FINAL;
            core_fsm_q <= CORE_R64;
            round_q    <= RIDX_W'(ROUNDS);
          end else begin
            rcnt_q     <= rcnt_q + RCNT_W'(1);
            round_q    <= round_nx_c;
            core_fsm_q <= (round_nx_c < RIDX_W'(WORDS)) ? CORE_R0_15 : CORE_R16_63;
          end
        end
        S_FINAL: begin
          // A missing final-add valid leaves the chain untouched and flags the block.
          if (!core_valid_in) begin
            err_q <= 1'b1;
          end
          state_q    <= S_DONE;
          core_fsm_q <= CORE_IDLE;
          round_q    <= '0;
          done_q     <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  sha256_chain_reg u_chain (
    .CLK            (CLK),
    .RST            (RST),
    .load_iv_i      (load_iv_c),
    .iv_i           (iv_c),
    .capture_i      (capture_c),
    .capture_data_i (core_digest_in),
    .chain_o        (chain_c)
  );

  assign msg_ready_out  = ready_q;
  assign sched_we_out   = we_q;
  assign sched_idx_out  = idx_q;
  assign sched_data_out = data_q;
  assign core_start_out = core_start_q;
  assign core_fsm_out   = core_fsm_q;
  assign core_round_out = round_q;
  assign chain_out      = chain_c;
  assign digest_out     = chain_c;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign error_out      = err_q;
`ifdef SHA224_MODE_EN
  assign digest224_out  = chain_c[255:32];
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl; the bench plays the compression core.
// Define SHA224_MODE_EN to also cover the SHA-224 IV and digest224_out.
module tb_sha256_round_ctrl;

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC   = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] H1    = {32'h85e655d6, 32'h417a1795, 32'h3363376a, 32'h624cde5c,
                                    32'h76e09589, 32'hcac5f811, 32'hcc4b32c1, 32'hf20e533a};
  localparam logic [255:0] TWO   = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic start_in = 1'b0, first_block_in = 1'b0, msg_valid_in = 1'b0;
  logic [31:0] msg_data_in = '0;
  logic msg_ready_out, sched_we_out, core_start_out, core_valid_in;
  logic [3:0] sched_idx_out;
  logic [31:0] sched_data_out;
  logic [1:0] core_fsm_out;
  logic [6:0] core_round_out;
  logic [255:0] chain_out, core_digest_in, digest_out;
  logic busy_out, done_out, error_out;
`ifdef SHA224_MODE_EN
  logic mode224_in = 1'b0;
  logic [223:0] digest224_out;
`endif

  logic [255:0] core_val = '0;
  logic core_ok = 1'b0;
  logic [31:0] msg [16];
  int total = 0, bad = 0, ncyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) ncyc <= ncyc + 1;

  // Core stub: presents its final state only while the controller is in the final-add step.
  assign core_valid_in  = (core_fsm_out == 2'd3) && core_ok;
  assign core_digest_in = core_val;

  sha256_round_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .start_in       (start_in),
    .first_block_in (first_block_in),
    .msg_valid_in   (msg_valid_in),
    .msg_data_in    (msg_data_in),
    .msg_ready_out  (msg_ready_out),
    .sched_we_out   (sched_we_out),
    .sched_idx_out  (sched_idx_out),
    .sched_data_out (sched_data_out),
    .core_start_out (core_start_out),
    .core_fsm_out   (core_fsm_out),
    .core_round_out (core_round_out),
    .chain_out      (chain_out),
    .core_digest_in (core_digest_in),
    .core_valid_in  (core_valid_in),
    .digest_out     (digest_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .error_out      (error_out)
`ifdef SHA224_MODE_EN
    ,
    .mode224_in     (mode224_in),
    .digest224_out  (digest224_out)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  256'(busy_out), 256'(0));
    chk({tag, "_ready"}, 256'(msg_ready_out), 256'(0));
    chk({tag, "_we"},    256'(sched_we_out), 256'(0));
    chk({tag, "_cst"},   256'(core_start_out), 256'(0));
    chk({tag, "_fsm"},   256'(core_fsm_out), 256'(0));
    chk({tag, "_rnd"},   256'(core_round_out), 256'(0));
    chk({tag, "_done"},  256'(done_out), 256'(0));
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  // One block: start, 16 words (optional gap after word 5), rounds, final, done.
  task automatic run_block(input logic first, input logic m224, input logic [255:0] dig,
                           input logic ok, input int gap, input int pulse_rel,
                           input bit start_at_done, input int rst_rel,
                           input logic [255:0] exp_start);
    int t0, c, rel, dones, post;
    bit seen, aborted;
    logic [255:0] exp_end;
    exp_end = ok ? dig : exp_start;
    core_val = dig;
    core_ok = ok;
    dones = 0; post = 0; seen = 0; aborted = 0;
    @(posedge CLK); #1;
    start_in = 1'b1;
    first_block_in = first;
`ifdef SHA224_MODE_EN
    mode224_in = m224;
`else
    if (m224) $display("note: mode224 request ignored in SHA-256-only build");
`endif
    msg_valid_in = 1'b0;
    @(posedge CLK); #1;
    t0 = ncyc;
    start_in = 1'b0;
    first_block_in = 1'b0;
    chk("load_ready", 256'(msg_ready_out), 256'(1));
    chk("load_busy", 256'(busy_out), 256'(1));
    chk("chain_at_start", chain_out, exp_start);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        for (int g = 0; g < gap; g++) begin
          msg_valid_in = 1'b0;
          @(posedge CLK); #1;
          chk("gap_we", 256'(sched_we_out), 256'(0));
          chk("gap_ready", 256'(msg_ready_out), 256'(1));
        end
      end
      msg_valid_in = 1'b1;
      msg_data_in = msg[i];
      @(posedge CLK); #1;
      chk("beat_we", 256'(sched_we_out), 256'(1));
      chk("beat_idx", 256'(sched_idx_out), 256'(i));
      chk("beat_data", 256'(sched_data_out), 256'(msg[i]));
    end
    chk("init_ready", 256'(msg_ready_out), 256'(0));
    chk("init_cstart", 256'(core_start_out), 256'(1));
    chk("init_fsm", 256'(core_fsm_out), 256'(0));
    // Junk words during the rounds must not reach the schedule store.
    msg_data_in = 32'hdeadbeef;
    for (int n = 0; n < 120 && post < 3; n++) begin
      @(posedge CLK); #1;
      c = ncyc - t0 + 1;
      rel = c - (18 + gap);
      start_in = 1'b0;
      chk("stray_we", 256'(sched_we_out), 256'(0));
      if (rst_rel >= 0 && rel == rst_rel) begin
        #2 RST = 1'b0;
        #1;
        check_idle_outputs("rst");
        chk("rst_chain", chain_out, IV256);
        chk("rst_digest", digest_out, IV256);
        chk("rst_err", 256'(error_out), 256'(0));
        msg_valid_in = 1'b0;
        #2 RST = 1'b1;
        aborted = 1;
        break;
      end
      if (!seen) begin
        if (rel >= 0 && rel < 64) begin
          chk("round_fsm", 256'(core_fsm_out), (rel < 16) ? 256'(1) : 256'(2));
          chk("round_idx", 256'(core_round_out), 256'(rel));
          chk("round_cstart", 256'(core_start_out), 256'(0));
        end else if (rel == 64) begin
          chk("final_fsm", 256'(core_fsm_out), 256'(3));
          chk("final_idx", 256'(core_round_out), 256'(64));
        end
        chk("run_busy", 256'(busy_out), 256'(1));
      end
      if (pulse_rel >= 0 && rel == pulse_rel) start_in = 1'b1;
      if (done_out) begin
        dones++;
        if (!seen) chk("done_cycle", 256'(c), 256'(83 + gap));
        seen = 1;
        if (start_at_done) start_in = 1'b1;
      end else if (seen) begin
        post++;
      end
    end
    msg_valid_in = 1'b0;
    start_in = 1'b0;
    if (!aborted) begin
      chk("done_count", 256'(dones), 256'(1));
      check_idle_outputs("after");
      chk("digest", digest_out, exp_end);
      chk("chain_end", chain_out, exp_end);
    end
  endtask

  initial begin
    #23;
    check_idle_outputs("reset");
    chk("reset_chain", chain_out, IV256);
    chk("reset_digest", digest_out, IV256);
    chk("reset_err", 256'(error_out), 256'(0));
    chk("reset_idx", 256'(sched_idx_out), 256'(0));
    chk("reset_data", 256'(sched_data_out), 256'(0));
    RST = 1'b1;

    // Words offered while idle are ignored.
    @(posedge CLK); #1;
    msg_valid_in = 1'b1;
    msg_data_in = 32'h12345678;
    @(posedge CLK); #1;
    chk("idle_we", 256'(sched_we_out), 256'(0));
    chk("idle_ready", 256'(msg_ready_out), 256'(0));
    msg_valid_in = 1'b0;

    set_abc();
    run_block(1'b1, 1'b0, ABC, 1'b1, 0, -1, 1'b0, -1, IV256);

    msg[0] = 32'h61626364; msg[1] = 32'h62636465; msg[2] = 32'h63646566; msg[3] = 32'h64656667;
    msg[4] = 32'h65666768; msg[5] = 32'h66676869; msg[6] = 32'h6768696a; msg[7] = 32'h68696a6b;
    msg[8] = 32'h696a6b6c; msg[9] = 32'h6a6b6c6d; msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
    msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071; msg[14] = 32'h80000000; msg[15] = 32'h0;
    run_block(1'b1, 1'b0, H1, 1'b1, 0, -1, 1'b0, -1, IV256);
    for (int i = 0; i < 15; i++) msg[i] = 32'h0;
    msg[15] = 32'h000001c0;
    run_block(1'b0, 1'b0, TWO, 1'b1, 0, -1, 1'b0, -1, H1);

    set_abc();
    run_block(1'b1, 1'b0, ABC, 1'b1, 3, -1, 1'b0, -1, IV256);
    run_block(1'b1, 1'b0, ABC, 1'b1, 0, 20, 1'b1, -1, IV256);
    run_block(1'b0, 1'b0, ABC, 1'b1, 0, -1, 1'b0, 40, ABC);
    run_block(1'b0, 1'b0, ABC, 1'b1, 0, -1, 1'b0, -1, IV256);
    chk("no_err", 256'(error_out), 256'(0));

    // Core never asserts valid: chain holds, error flag sticks until reset.
    run_block(1'b0, 1'b0, 256'h1, 1'b0, 0, -1, 1'b0, -1, ABC);
    chk("err_set", 256'(error_out), 256'(1));
    @(posedge CLK); #1;
    chk("err_sticky", 256'(error_out), 256'(1));
    RST = 1'b0;
    #2;
    chk("err_clear", 256'(error_out), 256'(0));
    RST = 1'b1;

`ifdef SHA224_MODE_EN
    run_block(1'b1, 1'b1, {32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                           32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h5a5a5a5a},
              1'b1, 0, -1, 1'b0, -1,
              {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4});
    chk("digest224", 256'(digest224_out),
        256'({32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
              32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
